cpu_clock_gate_ctrl: RTL and testbench
======================================

// Module: cpu_clock_gate_ctrl
// PURPOSE
//  Consumes the free-running CLK from the clock generator and produces a registered clock-enable (CPU_CE) for the accumulator processor.
//  Supports RUN, HALT and single-STEP modes, stop on processor HALT instruction, and a cycle-count breakpoint.
//  Sits between the clock source and every CE-gated register in the datapath/control unit.
// PARAMETERS
//  CNT_W            16  width of CYCLE_CNT and BRK_CYCLE
//  DEBOUNCE_CYCLES   4  stable-cycles required on step button (used only with STEP_DEBOUNCE_EN)
// PORTS
//  CLK         in   1      free-running clock; all state on rising edge
//  RST_N       in   1      asynchronous, active-low reset
//  RUN_REQ     in   1      level: 1 = run requested
//  STEP_BTN    in   1      raw async step button, active high
//  CPU_HALT    in   1      1-cycle pulse from processor: HALT instruction executed
//  BRK_EN      in   1      breakpoint enable
//  BRK_CYCLE   in   CNT_W  breakpoint cycle count
//  CPU_CE      out  1      registered processor clock enable
//  CYCLE_CNT   out  CNT_W  count of CE-enabled cycles since reset
//  STATE       out  2      current state encoding (pkg)
//  STOP_CAUSE  out  2      [0]=CPU_HALT, [1]=breakpoint; sticky until leaving STOPPED
// BEHAVIOUR
//  Reset (RST_N=0, async): STATE=HALT, CPU_CE=0, CYCLE_CNT=0, STOP_CAUSE=0, sync/debounce regs=0. Reset mid-run drops CE immediately.
//  States: HALT, RUN, STEP, STOPPED. CPU_CE=1 iff STATE in {RUN, STEP}. CE is a register; 1-cycle latency from sampled input.
//  HALT: RUN_REQ=1 -> RUN; else step_pulse -> STEP.
//  RUN: CPU_HALT=1 or brk_hit -> STOPPED (STOP_CAUSE set); else RUN_REQ=0 -> HALT. step_pulse ignored.
//  STEP: always -> HALT (CE high exactly one cycle). CPU_HALT during STEP sets STOP_CAUSE[0] and -> STOPPED.
//  STOPPED: RUN_REQ=0 -> HALT (STOP_CAUSE cleared); step_pulse -> STEP (STOP_CAUSE cleared). RUN_REQ held high never restarts.
//  Priority in one cycle: CPU_HALT/brk_hit > RUN_REQ=0 > step_pulse. CPU_HALT and brk_hit together set both STOP_CAUSE bits.
//  CYCLE_CNT increments at each edge where CPU_CE=1; wraps all-ones -> 0.
//  brk_hit = BRK_EN & CPU_CE & (CYCLE_CNT+1 == BRK_CYCLE) (CNT_W-bit compare): CYCLE_CNT freezes at exactly BRK_CYCLE.
//  Match only on increment: starting RUN with CYCLE_CNT==BRK_CYCLE does not stop until the counter wraps back.
//  Step path: STEP_BTN -> 2-FF sync -> rising-edge detect -> step_pulse (1 cycle per press).
//  Without debounce: CE asserted after the 3rd rising edge following STEP_BTN rise.
// CONFIGURATION
//  Macro STEP_DEBOUNCE_EN defined: synced button must hold a value DEBOUNCE_CYCLES consecutive cycles before the filtered level changes;
//  edge detect on the filtered level; latency 3+DEBOUNCE_CYCLES edges; glitches shorter than DEBOUNCE_CYCLES produce no step.
//  Macro STEP_DEBOUNCE_EN undefined: no filter, no counter instantiated; every synced rising edge produces one step_pulse.
// STRUCTURE
//  Package clk_ctrl_pkg: state encodings (HALT=2'b00, RUN=2'b01, STEP=2'b10, STOPPED=2'b11), STOP_CAUSE bit indices.
//  Sub-module step_sync_debounce: sync, optional debounce, edge detect; output step_pulse.
//  Top: state FSM, CE register, cycle counter, breakpoint compare.
// TESTING
//  1 Reset then RUN_REQ=1 for 10 cycles, then 0 -> CE high 10 cycles starting 1 cycle after RUN_REQ; CYCLE_CNT=10; STATE=HALT.
//  2 BRK_EN=1, BRK_CYCLE=5, RUN_REQ=1 from reset -> exactly 5 CE cycles; CYCLE_CNT=5; STATE=STOPPED; STOP_CAUSE=2'b10; stays stopped with RUN_REQ=1.
//  3 CPU_HALT pulse on same edge as brk_hit (BRK_CYCLE=3) -> STOPPED, STOP_CAUSE=2'b11; RUN_REQ=0 -> HALT, STOP_CAUSE=0.
//  4 In HALT, three STEP_BTN presses (high 8 cycles, low 8) -> three single-cycle CE pulses; CYCLE_CNT=3. With macro, 2-cycle glitch -> no pulse.
//  5 Preload via run to CYCLE_CNT=16'hFFFF, one step -> CYCLE_CNT=0; RST_N low mid-RUN -> CE=0 same cycle, CYCLE_CNT=0.
//  6 STEP_BTN pressed while RUN -> ignored, no extra CE, STATE stays RUN.

Source files
------------

// File: rtl/clk_ctrl_pkg.sv
// Shared encodings for the CPU clock-enable controller: FSM state codes,
// stop-cause bit positions and the state-to-CE decode.
package clk_ctrl_pkg;

  localparam logic [1:0] ST_HALT    = 2'b00;
  localparam logic [1:0] ST_RUN     = 2'b01;
  localparam logic [1:0] ST_STEP    = 2'b10;
  localparam logic [1:0] ST_STOPPED = 2'b11;

  localparam int CAUSE_HALT_BIT = 0;
  localparam int CAUSE_BRK_BIT  = 1;

  // The processor is clocked only while running freely or taking a single step.
  function automatic logic ce_for_state(input logic [1:0] st);
    return (st == ST_RUN) || (st == ST_STEP);
  endfunction

endpackage

// File: rtl/step_sync_debounce.sv
// Step-button front end: 2-FF synchroniser, optional debounce filter
// (enabled by macro STEP_DEBOUNCE_EN) and rising-edge detector.
module step_sync_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic step_pulse
);

  logic sync1;
  logic sync2;
  logic level;
  logic level_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the two sync stages into one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

`ifdef STEP_DEBOUNCE_EN
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [DB_W-1:0] db_cnt;
  logic            filt;

  // The filtered level follows sync2 only after it has disagreed for
  // DEBOUNCE_CYCLES consecutive samples; any agreement restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt <= '0;
      filt   <= 1'b0;
    end else if (sync2 == filt) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
      db_cnt <= '0;
      filt   <= sync2;
    end else begin
      db_cnt <= db_cnt + DB_W'(1);
    end
  end

  assign level = filt;
`else
  assign level = sync2;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) level_q <= 1'b0;
    else        level_q <= level;
  end

  assign step_pulse = level & ~level_q;

endmodule

// File: rtl/cpu_clock_gate_ctrl.sv
// Processor clock-enable controller: RUN/HALT/STEP/STOPPED FSM, registered
// CPU_CE, cycle counter and cycle breakpoint. Optional macro: STEP_DEBOUNCE_EN.
module cpu_clock_gate_ctrl
  import clk_ctrl_pkg::*;
#(
  parameter int CNT_W           = 16,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             RUN_REQ,
  input  logic             STEP_BTN,
  input  logic             CPU_HALT,
  input  logic             BRK_EN,
  input  logic [CNT_W-1:0] BRK_CYCLE,
  output logic             CPU_CE,
  output logic [CNT_W-1:0] CYCLE_CNT,
  output logic [1:0]       STATE,
  output logic [1:0]       STOP_CAUSE
);

  logic             step_pulse;
  logic [CNT_W-1:0] cnt_inc;
  logic             brk_hit;
  logic             stop_req;
  logic [1:0]       next_state;
  logic [1:0]       next_cause;

  step_sync_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_step (
    .clk       (CLK),
    .rst_n     (RST_N),
    .btn       (STEP_BTN),
    .step_pulse(step_pulse)
  );

  // Compare against the value the counter is about to take, so the count
  // freezes exactly on BRK_CYCLE and never matches on an idle counter.
  assign cnt_inc  = CYCLE_CNT + 1'b1;
  assign brk_hit  = BRK_EN & CPU_CE & (cnt_inc == BRK_CYCLE);
  assign stop_req = CPU_HALT | brk_hit;

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs; no latches.
    next_state = STATE;
    next_cause = STOP_CAUSE;
    case (STATE)
      ST_HALT: begin
        if (RUN_REQ)         next_state = ST_RUN;
        else if (step_pulse) next_state = ST_STEP;
      end
      ST_RUN, ST_STEP: begin
        if (stop_req) begin
          next_state                 = ST_STOPPED;
          next_cause[CAUSE_HALT_BIT] = CPU_HALT;
          next_cause[CAUSE_BRK_BIT]  = brk_hit;
        end else if (STATE == ST_STEP || !RUN_REQ) begin
          next_state = ST_HALT;
        end
      end
      default: begin
        // Stopped: a still-high RUN_REQ must be dropped before running again.
        if (!RUN_REQ) begin
          next_state = ST_HALT;
          next_cause = '0;
        end else if (step_pulse) begin
          next_state = ST_STEP;
          next_cause = '0;
        end
      end
    endcase
  end

  // NOTE: only control/status flops here, all with async reset; reset must
  // kill CE immediately, without waiting for a clock edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      STATE      <= ST_HALT;
      CPU_CE     <= 1'b0;
      STOP_CAUSE <= '0;
      CYCLE_CNT  <= '0;
    end else begin
      STATE      <= next_state;
      CPU_CE     <= ce_for_state(next_state);
      STOP_CAUSE <= next_cause;
      if (CPU_CE) CYCLE_CNT <= cnt_inc;
    end
  end

endmodule

// File: tb/tb_cpu_clock_gate_ctrl.sv
// Scoreboard bench for cpu_clock_gate_ctrl: stimulus queues the CYCLE_CNT
// expected in each CE-high cycle, a monitor pops one entry per CE cycle.
module tb_cpu_clock_gate_ctrl;

  localparam logic [1:0] S_HALT = 2'b00, S_RUN = 2'b01, S_STEP = 2'b10, S_STOP = 2'b11;
`ifdef STEP_DEBOUNCE_EN
  localparam int LAT = 3 + 4;
`else
  localparam int LAT = 3;
`endif

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        RUN_REQ = 1'b0;
  logic        STEP_BTN = 1'b0;
  logic        CPU_HALT = 1'b0;
  logic        BRK_EN = 1'b0;
  logic [15:0] BRK_CYCLE = '0;
  logic        CPU_CE;
  logic [15:0] CYCLE_CNT;
  logic [1:0]  STATE;
  logic [1:0]  STOP_CAUSE;

  int checks   = 0;
  int failures = 0;
  logic [15:0] exp_q[$];

  cpu_clock_gate_ctrl dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .RUN_REQ   (RUN_REQ),
    .STEP_BTN  (STEP_BTN),
    .CPU_HALT  (CPU_HALT),
    .BRK_EN    (BRK_EN),
    .BRK_CYCLE (BRK_CYCLE),
    .CPU_CE    (CPU_CE),
    .CYCLE_CNT (CYCLE_CNT),
    .STATE     (STATE),
    .STOP_CAUSE(STOP_CAUSE)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every CE-high cycle must have been announced by the stimulus.
  always @(negedge CLK) begin
    if (RST_N && CPU_CE) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ce", {16'h0, CYCLE_CNT}, 32'hDEAD_BEEF);
      end else begin
        check("ce_cycle_cnt", {16'h0, CYCLE_CNT}, {16'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #2;
  endtask

  task automatic expect_status(input string tag, input logic [1:0] st, input logic ce,
                               input logic [15:0] cnt, input logic [1:0] cause);
    check({tag, "_state"}, {30'h0, STATE}, {30'h0, st});
    check({tag, "_ce"}, {31'h0, CPU_CE}, {31'h0, ce});
    check({tag, "_cnt"}, {16'h0, CYCLE_CNT}, {16'h0, cnt});
    check({tag, "_cause"}, {30'h0, STOP_CAUSE}, {30'h0, cause});
  endtask

  task automatic do_reset();
    RUN_REQ = 1'b0; STEP_BTN = 1'b0; CPU_HALT = 1'b0; BRK_EN = 1'b0; BRK_CYCLE = '0;
    RST_N = 1'b0;
    #1;
    expect_status("reset", S_HALT, 1'b0, 16'h0, 2'b00);
    tick(2);
    RST_N = 1'b1;
    tick(1);
  endtask

  task automatic push_range(input int first, input int last);
    for (int i = first; i <= last; i++) exp_q.push_back(16'(i));
  endtask

  // One press: 8 cycles high, 8 low; CE must rise exactly LAT edges after the press.
  task automatic press(input logic [15:0] exp_cnt);
    exp_q.push_back(exp_cnt);
    STEP_BTN = 1'b1;
    tick(LAT - 1);
    check("step_latency_early", {31'h0, CPU_CE}, 32'h0);
    tick(1);
    check("step_ce_on", {31'h0, CPU_CE}, 32'h1);
    check("step_state", {30'h0, STATE}, {30'h0, S_STEP});
    tick(1);
    check("step_single_cycle", {31'h0, CPU_CE}, 32'h0);
    tick(8 - LAT - 1);
    STEP_BTN = 1'b0;
    tick(8);
  endtask

  initial begin
    // 1: plain run for 10 sampled cycles
    do_reset();
    RUN_REQ = 1'b1;
    push_range(0, 9);
    tick(1);
    check("run_ce_latency", {31'h0, CPU_CE}, 32'h1);
    tick(9);
    expect_status("run_mid", S_RUN, 1'b1, 16'd9, 2'b00);
    RUN_REQ = 1'b0;
    tick(1);
    expect_status("run_end", S_HALT, 1'b0, 16'd10, 2'b00);

    // 2: breakpoint at 5
    do_reset();
    BRK_EN = 1'b1; BRK_CYCLE = 16'd5; RUN_REQ = 1'b1;
    push_range(0, 4);
    tick(6);
    expect_status("brk5", S_STOP, 1'b0, 16'd5, 2'b10);
    tick(5);
    expect_status("brk5_hold", S_STOP, 1'b0, 16'd5, 2'b10);
    RUN_REQ = 1'b0;
    tick(1);
    expect_status("brk5_release", S_HALT, 1'b0, 16'd5, 2'b00);

    // 3: CPU_HALT on the same edge as the breakpoint hit
    do_reset();
    BRK_EN = 1'b1; BRK_CYCLE = 16'd3; RUN_REQ = 1'b1;
    push_range(0, 2);
    tick(3);
    CPU_HALT = 1'b1;
    tick(1);
    CPU_HALT = 1'b0;
    expect_status("halt_brk", S_STOP, 1'b0, 16'd3, 2'b11);
    RUN_REQ = 1'b0;
    tick(1);
    expect_status("halt_brk_release", S_HALT, 1'b0, 16'd3, 2'b00);

    // 4: three single steps from HALT, then a 2-cycle glitch
    do_reset();
    press(16'd0);
    press(16'd1);
    press(16'd2);
    expect_status("steps3", S_HALT, 1'b0, 16'd3, 2'b00);
`ifdef STEP_DEBOUNCE_EN
    STEP_BTN = 1'b1; tick(2); STEP_BTN = 1'b0; tick(12);
    expect_status("glitch_filtered", S_HALT, 1'b0, 16'd3, 2'b00);
`else
    exp_q.push_back(16'd3);
    STEP_BTN = 1'b1; tick(2); STEP_BTN = 1'b0; tick(12);
    expect_status("short_press_steps", S_HALT, 1'b0, 16'd4, 2'b00);
`endif

    // 5: wrap all-ones -> 0 via breakpoint preload, then reset mid-run
    do_reset();
    BRK_EN = 1'b1; BRK_CYCLE = 16'hFFFF; RUN_REQ = 1'b1;
    push_range(0, 16'hFFFE);
    tick(65536);
    expect_status("preload", S_STOP, 1'b0, 16'hFFFF, 2'b10);
    RUN_REQ = 1'b0; BRK_EN = 1'b0;
    tick(1);
    press(16'hFFFF);
    expect_status("wrap", S_HALT, 1'b0, 16'h0000, 2'b00);
    RUN_REQ = 1'b1;
    push_range(16'd0, 16'd1);
    tick(3);
    check("pre_reset_ce", {31'h0, CPU_CE}, 32'h1);
    RST_N = 1'b0;
    #1;
    expect_status("async_reset", S_HALT, 1'b0, 16'h0, 2'b00);
    RUN_REQ = 1'b0;
    tick(2);
    RST_N = 1'b1;
    tick(1);

    // 6: step button ignored while running
    do_reset();
    RUN_REQ = 1'b1;
    push_range(0, 19);
    tick(2);
    STEP_BTN = 1'b1; tick(8);
    STEP_BTN = 1'b0; tick(10);
    expect_status("run_step_ignored", S_RUN, 1'b1, 16'd19, 2'b00);
    RUN_REQ = 1'b0;
    tick(1);
    expect_status("run_step_end", S_HALT, 1'b0, 16'd20, 2'b00);
    tick(10);
    expect_status("run_step_idle", S_HALT, 1'b0, 16'd20, 2'b00);

    check("ce_queue_drained", exp_q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
